resolution_overlay_ctrl: RTL and testbench

- Sequences the 16-row x 40-bit resolution character ROM to draw the current mode's resolution text as a pixel overlay.
- On each line inside the overlay box it computes the ROM row, issues the address, and latches the 40-bit row after the ROM's 1-cycle latency.
- It then serializes the row MSB-first, with each bit scaled horizontally and vertically.
- Sits between the video timing counters and the pixel mixer.

---
 rtl/resolution_overlay_ctrl_if.sv | 36 +++
 rtl/resolution_overlay_ctrl.sv | 177 +++++++++++++++++
 tb/tb_resolution_overlay_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/resolution_overlay_ctrl_if.sv
// resolution_overlay_ctrl_if: video timing inputs and resolution ROM bus
// for the resolution text overlay controller.
// master: the overlay controller (drives rom_addr).
// slave : the timing generator / ROM side.
interface resolution_overlay_ctrl_if;

  typedef struct packed {
    logic [3:0] id;
  } VideoMode;

  VideoMode    videoMode;
  logic [11:0] counterX;
  logic [11:0] counterY;
  logic        line_start;
  logic [3:0]  rom_addr;
  logic [39:0] rom_q;

  modport master (
    input  videoMode,
    input  counterX,
    input  counterY,
    input  line_start,
    input  rom_q,
    output rom_addr
  );

  modport slave (
    output videoMode,
    output counterX,
    output counterY,
    output line_start,
    output rom_q,
    input  rom_addr
  );

endinterface

// File: rtl/resolution_overlay_ctrl.sv
// resolution_overlay_ctrl: fetches one 40-bit row of the resolution character
// ROM per overlay line and serializes it MSB-first, each bit replicated
// (1 << SCALE_LOG2) pixels wide and lines tall.
// Optional border output: define RESOLUTION_OVERLAY_BORDER_EN.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for line_start on a line inside the box
// ST_FETCH | rom_addr holds the ROM row for this line
// ST_WAIT  | ROM read latency
// ST_LOAD  | latch rom_q into the shift register, clear counters
// ST_ARMED | row loaded, waiting for counterX == X0
// ST_SHIFT | serializing the row
module resolution_overlay_ctrl #(
  parameter int X0         = 64,
  parameter int Y0         = 32,
  parameter int SCALE_LOG2 = 1
) (
  input  logic                              clock,
  input  logic                              resetn,
  resolution_overlay_ctrl_if.master         bus,
  output logic                              pixel_on,
  output logic                              box_active
`ifdef RESOLUTION_OVERLAY_BORDER_EN
  ,
  output logic                              border_on
`endif
);

  localparam int          H       = 16 << SCALE_LOG2;
  localparam logic [1:0]  REP_MAX = 2'((1 << SCALE_LOG2) - 1);
  localparam logic [11:0] X0_C    = 12'(X0);
  localparam logic [11:0] Y0_C    = 12'(Y0);
  localparam logic [11:0] Y_END_C = 12'(Y0 + H);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_LOAD  = 3'd3,
    ST_ARMED = 3'd4,
    ST_SHIFT = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  mode_q;
  logic [3:0]  rom_addr_q, rom_addr_d;
  logic [39:0] shreg_q, shreg_d;
  logic [5:0]  bitcnt_q, bitcnt_d;
  logic [1:0]  repcnt_q, repcnt_d;
  logic        pixel_q, pixel_d;
  logic        box_q, box_d;

  logic        mode_chg;
  logic        line_in_box;
  logic [11:0] dy;
  logic [3:0]  row;
  logic        start_x;
  logic        rep_last;
  logic        last_bit;
  logic        draw;

  // A mode change aborts everything; the overlay simply resumes next line.
  assign mode_chg    = bus.videoMode.id != mode_q;
  assign line_in_box = (bus.counterY >= Y0_C) && (bus.counterY < Y_END_C);
  assign dy          = bus.counterY - Y0_C;
  assign row         = 4'(dy >> SCALE_LOG2);
  assign start_x     = bus.counterX == X0_C;
  assign rep_last    = repcnt_q == REP_MAX;
  assign last_bit    = bitcnt_q == 6'd39;
  // The sample at counterX == X0 is the first drawn one, so drawing starts in
  // ARMED on that cycle and continues through SHIFT.
  assign draw        = !mode_chg && !bus.line_start &&
                       (((state_q == ST_ARMED) && start_x) || (state_q == ST_SHIFT));

  assign bus.rom_addr = rom_addr_q;
  assign pixel_on     = pixel_q;
  assign box_active   = box_q;

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; a new line_start restarts the sequence from any state.
  always_comb begin
    state_d = state_q;
    if (mode_chg) begin
      state_d = ST_IDLE;
    end else if (bus.line_start) begin
      state_d = line_in_box ? ST_FETCH : ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_IDLE;
        ST_FETCH: state_d = ST_WAIT;
        ST_WAIT:  state_d = ST_LOAD;
        ST_LOAD:  state_d = ST_ARMED;
        ST_ARMED: if (start_x) state_d = ST_SHIFT;
        ST_SHIFT: if (last_bit && rep_last) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Output and datapath next values: address capture, row load, serializer.
  always_comb begin
    rom_addr_d = rom_addr_q;
    shreg_d    = shreg_q;
    bitcnt_d   = bitcnt_q;
    repcnt_d   = repcnt_q;
    pixel_d    = draw && shreg_q[39];
    box_d      = draw;
    if (!mode_chg && bus.line_start && line_in_box) begin
      rom_addr_d = row;
    end
    if (state_q == ST_LOAD) begin
      shreg_d  = bus.rom_q;
      bitcnt_d = 6'd0;
      repcnt_d = 2'd0;
    end
    if (draw) begin
      if (rep_last) begin
        repcnt_d = 2'd0;
        shreg_d  = shreg_q << 1;
        bitcnt_d = bitcnt_q + 6'd1;
      end else begin
        repcnt_d = repcnt_q + 2'd1;
      end
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mode_q     <= 4'd0;
      rom_addr_q <= 4'd0;
      shreg_q    <= 40'd0;
      bitcnt_q   <= 6'd0;
      repcnt_q   <= 2'd0;
      pixel_q    <= 1'b0;
      box_q      <= 1'b0;
    end else begin
      mode_q     <= bus.videoMode.id;
      rom_addr_q <= rom_addr_d;
      shreg_q    <= shreg_d;
      bitcnt_q   <= bitcnt_d;
      repcnt_q   <= repcnt_d;
      pixel_q    <= pixel_d;
      box_q      <= box_d;
    end
  end

`ifdef RESOLUTION_OVERLAY_BORDER_EN
  localparam int          W      = 40 << SCALE_LOG2;
  localparam logic [11:0] XB_L_C = 12'(X0 - 1);
  localparam logic [11:0] XB_R_C = 12'(X0 + W);
  localparam logic [11:0] YB_T_C = 12'(Y0 - 1);
  localparam logic [11:0] YB_B_C = 12'(Y0 + H);

  logic border_q, border_d;
  logic x_inner, x_outer, y_outer;

  assign x_inner   = (bus.counterX >= X0_C) && (bus.counterX < XB_R_C);
  assign x_outer   = (bus.counterX >= XB_L_C) && (bus.counterX <= XB_R_C);
  assign y_outer   = (bus.counterY >= YB_T_C) && (bus.counterY <= YB_B_C);
  assign border_d  = x_outer && y_outer && !(x_inner && line_in_box);
  assign border_on = border_q;

  // One-pixel frame around the box, same latency as pixel_on.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) border_q <= 1'b0;
    else         border_q <= border_d;
  end
`endif

endmodule

// File: tb/tb_resolution_overlay_ctrl.sv
// Directed bench for resolution_overlay_ctrl: table of whole-line vectors
// plus hand sequences for latency, mode change, short line and reset.
module tb_resolution_overlay_ctrl;

  logic clock;
  logic resetn;
  logic pixel_on;
  logic box_active;

  int n_chk  = 0;
  int n_fail = 0;

  resolution_overlay_ctrl_if bus ();

  logic [39:0] rom [16];

`ifdef RESOLUTION_OVERLAY_BORDER_EN
  logic border_on;
  logic pixel_on0, box_active0, border_on0;
  resolution_overlay_ctrl_if bus0 ();
  assign bus0.videoMode  = bus.videoMode;
  assign bus0.counterX   = bus.counterX;
  assign bus0.counterY   = bus.counterY;
  assign bus0.line_start = bus.line_start;
  always @(posedge clock) bus0.rom_q <= rom[bus0.rom_addr];

  resolution_overlay_ctrl #(.X0(64), .Y0(32), .SCALE_LOG2(0)) dut0 (
    .clock(clock), .resetn(resetn), .bus(bus0),
    .pixel_on(pixel_on0), .box_active(box_active0), .border_on(border_on0)
  );
`endif

  resolution_overlay_ctrl #(.X0(64), .Y0(32), .SCALE_LOG2(1)) dut (
    .clock(clock), .resetn(resetn), .bus(bus),
    .pixel_on(pixel_on), .box_active(box_active)
`ifdef RESOLUTION_OVERLAY_BORDER_EN
    , .border_on(border_on)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ROM model: one cycle of read latency.
  always @(posedge clock) bus.rom_q <= rom[bus.rom_addr];

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic        s_pix, s_box;
  logic [3:0]  s_addr;
  logic [255:0] pix_v, box_v;
  logic [3:0]  addr_a [256];
`ifdef RESOLUTION_OVERLAY_BORDER_EN
  logic [255:0] brd_v, pix0_v, brd0_v;
`endif

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int first_one(input logic [255:0] v);
    for (int i = 0; i < 256; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int last_one(input logic [255:0] v);
    for (int i = 255; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  task automatic rom_fill(input logic [39:0] d);
    for (int i = 0; i < 16; i++) rom[i] = d;
  endtask

  // Sample outputs (result of the previous counterX), then drive the next one.
  task automatic step(input int x, input int y);
    @(negedge clock);
    s_pix  = pixel_on;
    s_box  = box_active;
    s_addr = bus.rom_addr;
    bus.counterX   = 12'(x);
    bus.counterY   = 12'(y);
    bus.line_start = (x == 0);
  endtask

  task automatic store(input int idx);
    pix_v[idx]  = s_pix;
    box_v[idx]  = s_box;
    addr_a[idx] = s_addr;
`ifdef RESOLUTION_OVERLAY_BORDER_EN
    brd_v[idx]  = border_on;
    pix0_v[idx] = pixel_on0;
    brd0_v[idx] = border_on0;
`endif
  endtask

  // Index i of the captured vectors holds the output produced by counterX == i.
  task automatic run_line(input int y, input int len, input int sw_at, input logic [3:0] sw_id);
    pix_v = '0;
    box_v = '0;
`ifdef RESOLUTION_OVERLAY_BORDER_EN
    brd_v = '0; pix0_v = '0; brd0_v = '0;
`endif
    for (int x = 0; x < len; x++) begin
      step(x, y);
      if (x > 0) store(x - 1);
      if (x == sw_at) bus.videoMode.id = sw_id;
    end
    step(len - 1, y);
    store(len - 1);
  endtask

  typedef struct {
    int          y;
    logic [39:0] data;
    bit          fetch;
    logic [3:0]  addr;
    int          pix_n;
    int          box_n;
    int          first;
  } vec_t;

  vec_t vecs [8];
  logic any_box;

  initial begin
    vecs[0] = '{35, 40'h80_0000_0001, 1'b1, 4'd1,  4,  80, 64};
    vecs[1] = '{31, 40'hFF_FFFF_FFFF, 1'b0, 4'd0,  0,  0,  -1};
    vecs[2] = '{64, 40'hFF_FFFF_FFFF, 1'b0, 4'd0,  0,  0,  -1};
    vecs[3] = '{63, 40'hFF_FFFF_FFFF, 1'b1, 4'd15, 80, 80, 64};
    vecs[4] = '{32, 40'h00_0000_0000, 1'b1, 4'd0,  0,  80, -1};
    vecs[5] = '{48, 40'h0F_0000_0000, 1'b1, 4'd8,  8,  80, 72};
    vecs[6] = '{33, 40'h00_0000_0003, 1'b1, 4'd0,  4,  80, 140};
    vecs[7] = '{47, 40'hAA_AAAA_AAAA, 1'b1, 4'd7,  40, 80, 64};

    resetn = 1'b0;
    bus.videoMode.id = 4'd1;
    bus.counterX = '0;
    bus.counterY = '0;
    bus.line_start = 1'b0;
    rom_fill(40'h0);
    repeat (3) @(negedge clock);
    chk("reset_rom_addr", bus.rom_addr, 0);
    chk("reset_pixel_on", pixel_on, 0);
    chk("reset_box_active", box_active, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clock);

    // Whole-line vectors.
    for (int v = 0; v < 8; v++) begin
      rom_fill(vecs[v].data);
      run_line(vecs[v].y, 160, -1, 4'd0);
      if (vecs[v].fetch) chk($sformatf("vec%0d_rom_addr", v), addr_a[0], vecs[v].addr);
      chk($sformatf("vec%0d_pix_count", v), $countones(pix_v), vecs[v].pix_n);
      chk($sformatf("vec%0d_box_count", v), $countones(box_v), vecs[v].box_n);
      chk($sformatf("vec%0d_first_pix", v), first_one(pix_v), vecs[v].first);
      if (vecs[v].box_n > 0) begin
        chk($sformatf("vec%0d_box_first", v), first_one(box_v), 64);
        chk($sformatf("vec%0d_box_last", v), last_one(box_v), 143);
      end
    end

    // Exact placement with 2x scaling.
    rom_fill(40'h80_0000_0001);
    run_line(35, 160, -1, 4'd0);
    chk("scale_addr_after_ls", addr_a[0], 1);
    chk("scale_pix63", pix_v[63], 0);
    chk("scale_pix64", pix_v[64], 1);
    chk("scale_pix65", pix_v[65], 1);
    chk("scale_pix66", pix_v[66], 0);
    chk("scale_pix141", pix_v[141], 0);
    chk("scale_pix142", pix_v[142], 1);
    chk("scale_pix143", pix_v[143], 1);
    chk("scale_pix144", pix_v[144], 0);
    chk("scale_box63", box_v[63], 0);
    chk("scale_box144", box_v[144], 0);

    // Mode change at counterX == 80, then a normal line.
    rom_fill(40'hFF_FFFF_FFFF);
    run_line(36, 160, 80, 4'd2);
    chk("mode_box79", box_v[79], 1);
    chk("mode_box80", box_v[80], 0);
    chk("mode_pix80", pix_v[80], 0);
    chk("mode_box_count", $countones(box_v), 16);
    chk("mode_pix_count", $countones(pix_v), 16);
    run_line(37, 160, -1, 4'd0);
    chk("mode_next_box_count", $countones(box_v), 80);
    chk("mode_next_pix_count", $countones(pix_v), 80);

    // Short line cut off mid-row, then a full line.
    run_line(40, 100, -1, 4'd0);
    run_line(41, 160, -1, 4'd0);
    chk("short_next_addr", addr_a[0], 4);
    chk("short_next_box_count", $countones(box_v), 80);
    chk("short_next_box_first", first_one(box_v), 64);
    chk("short_next_pix_count", $countones(pix_v), 80);

    // Reset in the middle of a drawn line.
    for (int x = 0; x <= 90; x++) step(x, 35);
    chk("pre_reset_box", s_box, 1);
    #1 resetn = 1'b0;
    #1;
    chk("mid_reset_pixel_on", pixel_on, 0);
    chk("mid_reset_box_active", box_active, 0);
    chk("mid_reset_rom_addr", bus.rom_addr, 0);
    for (int x = 91; x <= 93; x++) step(x, 35);
    resetn = 1'b1;
    any_box = 1'b0;
    for (int x = 94; x < 160; x++) begin
      step(x, 35);
      any_box = any_box | s_box | s_pix;
    end
    chk("post_reset_idle", any_box, 0);
    run_line(32, 160, -1, 4'd0);
    chk("post_reset_line32_box", $countones(box_v), 80);
    chk("post_reset_line32_pix", $countones(pix_v), 80);

`ifdef RESOLUTION_OVERLAY_BORDER_EN
    run_line(31, 160, -1, 4'd0);
    chk("border_s0_count", $countones(brd0_v), 42);
    chk("border_s0_first", first_one(brd0_v), 63);
    chk("border_s0_last", last_one(brd0_v), 104);
    chk("border_s0_pix", $countones(pix0_v), 0);
    chk("border_s1_count", $countones(brd_v), 82);
    run_line(32, 160, -1, 4'd0);
    chk("border_s0_side_count", $countones(brd0_v), 2);
    chk("border_s0_side_left", brd0_v[63], 1);
    chk("border_s0_side_right", brd0_v[104], 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
